// File: rtl/serial_logic_unit.sv
// Bit-serial N-bit logic unit: streams operand bit pairs LSB first through a
// single 1-bit logic cell and reassembles the result word.

// 1-bit logic cell: 00 AND, 01 OR, 10 XOR, 11 NOT a.
module cl (
    input  logic       a,
    input  logic       b,
    input  logic [1:0] S,
    output logic       f
);

    // Select the logic function for one bit pair.
    always_comb begin
        f = 1'b0;
        case (S)
            2'b00:   f = a & b;
            2'b01:   f = a | b;
            2'b10:   f = a ^ b;
            default: f = ~a;
        endcase
    end

endmodule

module serial_logic_unit #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   S,
    output logic [N-1:0] result,
    output logic         busy,
    output logic         done
);

    localparam int CW = (N > 1) ? $clog2(N + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   a_sh;
    logic [N-1:0]   b_sh;
    logic [1:0]     s_lat;
    logic [N-1:0]   r_sh;
    logic [N-1:0]   r_next;
    logic [CW-1:0]  cnt;
    logic           last;
    logic           bit_out;

    cl u_cl (
        .a (a_sh[0]),
        .b (b_sh[0]),
        .S (s_lat),
        .f (bit_out)
    );

    // Shift the new bit in at the MSB; after N shifts the first bit sits at bit 0.
    // Written as a shift of the concatenation so N = 1 needs no special slice.
    assign r_next = N'({bit_out, r_sh} >> 1);
    assign last   = (cnt == CW'(N - 1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and status decode.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, serial shift, bit count and result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            s_lat  <= '0;
            r_sh   <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        s_lat <= S;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    r_sh <= r_next;
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + CW'(1);
                    if (last) result <= r_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_logic_unit.md
# serial_logic_unit

Bit-serial N-bit logic unit built around the existing 1-bit logic cell `cl`. It latches two N-bit operands and a 2-bit operation code, streams one bit pair per clock (LSB first) through a single `cl` instance, and reassembles the N result bits into a word. It sits both upstream and downstream of `cl`: it feeds the cell its operand bits and select, and consumes the cell's output. It is the sequential alternative to instantiating N parallel cells.

## Interface

Parameters:
- `N`, default 8: operand/result width in bits. Legal range is N ≥ 1.

Ports:
- `clk`, input, 1 bit: single clock. All state updates on the rising edge.
- `reset`, input, 1 bit: asynchronous, active-high reset.
- `start`, input, 1 bit: request to begin an operation. Sampled only in IDLE.
- `a`, input, N bits: operand A. Latched on an accepted start.
- `b`, input, N bits: operand B. Latched on an accepted start.
- `S`, input, 2 bits: operation select, latched on an accepted start. Encoding: 00 = AND, 01 = OR, 10 = XOR, 11 = NOT a (b is ignored).
- `result`, output, N bits: registered result word. Bit i = op(a[i], b[i]).
- `busy`, output, 1 bit: high while in RUN.
- `done`, output, 1 bit: one-cycle pulse, high while in DONE.

## Operation

- Internal state:
  - FSM with states IDLE, RUN and DONE.
  - Operand shift registers `a_sh` and `b_sh`, N bits each.
  - Latched select `s_lat`, 2 bits.
  - Result shift register `r_sh`, N bits.
  - Bit counter `cnt`, width $clog2(N+1), minimum 1.
- The single `cl` instance is driven with inputs (`a_sh[0]`, `b_sh[0]`, `s_lat`). Its output is `bit_out`.
- IDLE:
  - `busy` = 0, `done` = 0.
  - If `start` = 1 at an edge: load `a_sh` ← `a`, `b_sh` ← `b`, `s_lat` ← `S`, `cnt` ← 0, then go to RUN.
  - Otherwise stay in IDLE.
- RUN, at each edge:
  - `r_sh` ← {`bit_out`, `r_sh[N-1:1]`}.
  - `a_sh` and `b_sh` each shift right by one.
  - `cnt` ← `cnt` + 1.
  - On the edge where `cnt` == N−1: also load `result` ← {`bit_out`, `r_sh[N-1:1]`} and go to DONE.
  - `start` is ignored throughout RUN.
- DONE:
  - `done` = 1 for exactly one cycle.
  - Go unconditionally to IDLE on the next edge.
  - `start` is ignored in DONE. A start held high through DONE is accepted on the first IDLE edge.
- `result`:
  - Changes only on the RUN→DONE transition and on reset.
  - Holds its value through subsequent IDLE periods and through the next RUN, until that run completes.
- Input changes on `a`, `b` or `S` after acceptance have no effect on the operation in flight.
- N = 1: RUN lasts one edge (`cnt` == 0 == N−1). The same transitions apply.

## Timing

- Reset (asynchronous, takes effect immediately, any state):
  - State ← IDLE.
  - `busy`, `done`, `result`, `cnt`, `a_sh`, `b_sh`, `s_lat`, `r_sh` ← 0.
  - A reset asserted mid-RUN aborts the operation. No `done` is produced and `result` reads 0.
- Call the edge that accepts `start` E0.
  - `busy` is high after E0 through EN.
  - `done` and a new `result` are visible after EN and stay so until E(N+1).
  - Start-to-done latency is N+1 edges. Issue interval is N+2 cycles, including the mandatory IDLE cycle.
- `busy` and `done` are never high simultaneously.
- First start after reset release: accepted on the first edge with `reset` = 0 and `start` = 1.

## Test plan

- AND, N = 8: a = 0xCA, b = 0x5F, S = 00, one-cycle start. Required: `busy` high for 8 cycles, then `done` pulses once with `result` = 0x4A, and `result` stays 0x4A afterwards.
- OR, XOR and NOT, back-to-back, with the same operands:
  - S = 01 gives 0xDF.
  - S = 10 gives 0x95.
  - S = 11 gives 0x35 (b ignored).
  - Each run's start is held high from its own DONE cycle. Check that every run is accepted exactly one cycle after the previous `done`.
- Input stability: change a, b and S to random values every cycle during RUN. Required: `result` matches the values latched at E0. Also hold `start` high through RUN and check that no extra operation starts until IDLE.
- Reset mid-operation: assert `reset` asynchronously (off-edge) at cycle 4 of a run. Required:
  - `busy`, `done` and `result` drop to 0 immediately, without waiting for an edge.
  - No `done` follows.
  - A fresh start with a = 0xFF, b = 0x0F, S = 00 yields 0x0F.
- N = 1 instance: a = 1, b = 0 for each of S = 00/01/10/11. Required: `result` = 0/1/1/0, with `busy` high 1 cycle and `done` 1 cycle later.
- Post-completion hold: after a 0x4A result, idle for 20 cycles with `start` = 0. Required: `result` stays 0x4A, `busy` = 0, `done` = 0.
